colorled_scan_ctrl: RTL and testbench

//  Scan scheduler for the colour-LED key/lamp matrix. Drives the row lines
//  (active-low one-hot), dwells on each row, samples the column sense lines,

---
 rtl/colorled_scan_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_colorled_scan_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/colorled_scan_ctrl.sv
//------------------------------------------------------------------------------
// colorled_scan_ctrl
//
// Scan scheduler for the colour-LED key/lamp matrix. Strobes one row at a
// time (active-low), lets the column lines settle, samples them once per row
// slot, debounces every key across frames and flips the key's lamp on each
// accepted press.
//
// Ports
//   clk            : system clock
//   rst            : synchronous reset, active-high
//   i_enable       : 1 = scan running, 0 = stop at the end of the current slot
//   i_sense        : column sense lines, active-low (0 = pressed), asynchronous
//   o_row_drive    : row strobe, active-low one-hot, all ones when idle
//   o_scan_row     : index of the driven row (kept while idle)
//   o_led_state    : lamp state, bit r*N_COLS+c, 0 = on, 1 = off
//   o_toggle_pulse : one-cycle pulse on every lamp that has just flipped
//   o_frame_done   : one-cycle pulse when the row index wraps back to 0
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module colorled_scan_ctrl #(
  parameter int N_ROWS       = 4,
  parameter int N_COLS       = 3,
  parameter int DWELL_CYC    = 1000,
  parameter int SETTLE_CYC   = 8,
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_enable,
  input  logic [N_COLS-1:0]          i_sense,
  output logic [N_ROWS-1:0]          o_row_drive,
  output logic [$clog2(N_ROWS)-1:0]  o_scan_row,
  output logic [N_ROWS*N_COLS-1:0]   o_led_state,
  output logic [N_ROWS*N_COLS-1:0]   o_toggle_pulse,
  output logic                       o_frame_done
);

  localparam int ROW_W  = $clog2(N_ROWS);
  localparam int TIM_W  = $clog2(DWELL_CYC);
  localparam int DB_W   = $clog2(DEBOUNCE_CNT + 1);
  localparam int N_KEYS = N_ROWS * N_COLS;

  localparam logic [TIM_W-1:0] SAMPLE_AT = TIM_W'(SETTLE_CYC);
  localparam logic [TIM_W-1:0] SLOT_LAST = TIM_W'(DWELL_CYC - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(N_ROWS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [TIM_W-1:0]    timer_reg, timer_next;
  logic [ROW_W-1:0]    row_reg, row_next;
  logic [N_ROWS-1:0]   row_drive_reg, row_drive_next;
  logic                frame_done_reg, frame_done_next;
  logic [N_COLS-1:0]   sense_meta_reg, sense_sync_reg;
  logic                sample;

  // Two-flop synchroniser; idles at all ones (nothing pressed).
  always_ff @(posedge clk) begin
    if (rst) begin
      sense_meta_reg <= '1;
      sense_sync_reg <= '1;
    end else begin
      sense_meta_reg <= i_sense;
      sense_sync_reg <= sense_meta_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      timer_reg      <= '0;
      row_reg        <= '0;
      row_drive_reg  <= '1;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      timer_reg      <= timer_next;
      row_reg        <= row_next;
      row_drive_reg  <= row_drive_next;
      frame_done_reg <= frame_done_next;
    end
  end

  // The slot timer runs from 0 to DWELL_CYC-1 in SETTLE and HOLD alike, so a
  // slot always lasts DWELL_CYC cycles; the state only marks whether the
  // sample for this row has been taken yet.
  always_comb begin
    state_next      = state_reg;
    timer_next      = timer_reg;
    row_next        = row_reg;
    frame_done_next = 1'b0;
    sample          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_enable) begin
          state_next = SETTLE;
          timer_next = '0;
          row_next   = '0;
        end
      end
      SETTLE: begin
        timer_next = timer_reg + 1'b1;
        if (timer_reg == SAMPLE_AT) begin
          sample     = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (timer_reg == SLOT_LAST) begin
          timer_next = '0;
          if (i_enable) begin
            state_next = SETTLE;
            if (row_reg == ROW_LAST) begin
              row_next        = '0;
              frame_done_next = 1'b1;
            end else begin
              row_next = row_reg + 1'b1;
            end
          end else begin
            // Row index is kept so the last scanned row stays visible.
            state_next = IDLE;
          end
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase
  end

  // Row strobe is decoded from the next state and registered, so the pins
  // only ever change on a clock edge.
  genvar gi;
  generate
    for (gi = 0; gi < N_ROWS; gi++) begin : g_row
      assign row_drive_next[gi] = (state_next == IDLE) || (row_next != ROW_W'(gi));
    end
  endgenerate

  // Per-key debounce and lamp toggle. Each key is evaluated only on the
  // single sample taken while its own row is driven, i.e. once per frame.
  generate
    for (gi = 0; gi < N_KEYS; gi++) begin : g_key
      localparam int ROW = gi / N_COLS;
      localparam int COL = gi % N_COLS;

      logic [DB_W-1:0] cnt_reg;
      logic            pressed_reg;
      logic            led_reg;
      logic            toggle_reg;
      logic            raw_pressed;
      logic            hit;

      assign raw_pressed = ~sense_sync_reg[COL];
      assign hit         = sample && (row_reg == ROW_W'(ROW));

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg     <= '0;
          pressed_reg <= 1'b0;
          led_reg     <= 1'b1;
          toggle_reg  <= 1'b0;
        end else begin
          toggle_reg <= 1'b0;
          if (hit) begin
            if (raw_pressed == pressed_reg) begin
              cnt_reg <= '0;
            end else if (cnt_reg == DB_W'(DEBOUNCE_CNT - 1)) begin
              cnt_reg     <= '0;
              pressed_reg <= raw_pressed;
              // Only a released->pressed acceptance flips the lamp.
              if (raw_pressed) begin
                led_reg    <= ~led_reg;
                toggle_reg <= 1'b1;
              end
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
      end

      assign o_led_state[gi]    = led_reg;
      assign o_toggle_pulse[gi] = toggle_reg;
    end
  endgenerate

  assign o_row_drive  = row_drive_reg;
  assign o_scan_row   = row_reg;
  assign o_frame_done = frame_done_reg;

endmodule

// File: tb/tb_colorled_scan_ctrl.sv
//------------------------------------------------------------------------------
// tb_colorled_scan_ctrl
//
// Directed bench for colorled_scan_ctrl with N_ROWS=4, N_COLS=3, DWELL_CYC=16,
// SETTLE_CYC=4, DEBOUNCE_CNT=3. A tiny matrix model pulls column 2 low while
// row 1 is strobed and the key r1c2 is held. Outputs are sampled 1 ns after
// the rising edge. Slot positions below count edges from the first cycle a
// row is visible (position 0 = timer 0); the sample is taken at position 4
// so an accepted press shows at position 5.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_colorled_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [2:0]  sense;
  logic [3:0]  row_drive;
  logic [1:0]  scan_row;
  logic [11:0] led_state;
  logic [11:0] toggle_pulse;
  logic        frame_done;
  logic        key_held;

  int n_checks;
  int n_fail;

  colorled_scan_ctrl #(
    .N_ROWS(4), .N_COLS(3), .DWELL_CYC(16), .SETTLE_CYC(4), .DEBOUNCE_CNT(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_enable(enable),
    .i_sense(sense),
    .o_row_drive(row_drive),
    .o_scan_row(scan_row),
    .o_led_state(led_state),
    .o_toggle_pulse(toggle_pulse),
    .o_frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key r1c2: column 2 reads low only while row 1 is strobed.
  assign sense = (key_held && row_drive[1] == 1'b0) ? 3'b011 : 3'b111;

  // Advance until row r has just become the strobed row (position 0).
  task automatic wait_slot_start(input int r);
    logic [3:0] target;
    logic [3:0] prev;
    bit         found;
    target = ~(4'b0001 << r);
    prev   = row_drive;
    found  = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk); #1;
      if (row_drive == target && prev != target) found = 1'b1;
      prev = row_drive;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL wait_row%0d: row strobe got %b, required %b within 200 cycles", r, row_drive, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; key_held = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (row_drive !== 4'b1111 || scan_row !== 2'd0 || led_state !== 12'hFFF ||
        toggle_pulse !== 12'h000 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got rows=%b row=%0d led=%h tog=%h fd=%b, required 1111/0/fff/000/0",
               row_drive, scan_row, led_state, toggle_pulse, frame_done);
    end
    rst = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      n_checks++;
      if (row_drive !== 4'b1111 || led_state !== 12'hFFF || toggle_pulse !== 12'h000 ||
          frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_disabled n=%0d: got rows=%b led=%h tog=%h fd=%b, required 1111/fff/000/0",
                 n, row_drive, led_state, toggle_pulse, frame_done);
      end
    end
    $display("test_reset: done");
  endtask

  task automatic test_scan();
    logic [3:0] exp_rows;
    logic [1:0] exp_row;
    logic       exp_fd;
    enable = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n < 128; n++) begin
      exp_row  = 2'((n / 16) % 4);
      exp_rows = ~(4'b0001 << exp_row);
      exp_fd   = (n > 0) && (n % 64 == 0);
      n_checks++;
      if (row_drive !== exp_rows || scan_row !== exp_row) begin
        n_fail++;
        $display("FAIL scan_rows n=%0d: got rows=%b row=%0d, required %b/%0d", n, row_drive, scan_row, exp_rows, exp_row);
      end
      n_checks++;
      if (frame_done !== exp_fd) begin
        n_fail++;
        $display("FAIL scan_frame_done n=%0d: got %b, required %b", n, frame_done, exp_fd);
      end
      n_checks++;
      if (led_state !== 12'hFFF || toggle_pulse !== 12'h000) begin
        n_fail++;
        $display("FAIL scan_lamps n=%0d: got led=%h tog=%h, required fff/000", n, led_state, toggle_pulse);
      end
      @(posedge clk); #1;
    end
    $display("test_scan: done");
  endtask

  // Press for 3 frames, release for 3: one toggle of bit 5, none on release.
  task automatic test_toggle();
    logic [5:0]  pat = 6'b000111;
    int          tn  = 2 * 64 + 5;
    logic [11:0] exp_tog;
    logic [11:0] exp_led;
    wait_slot_start(1);
    for (int n = 0; n < 6 * 64; n++) begin
      if (n % 64 == 0) key_held = pat[n / 64];
      exp_tog = (n == tn) ? 12'h020 : 12'h000;
      exp_led = (n >= tn) ? 12'hFDF : 12'hFFF;
      n_checks++;
      if (toggle_pulse !== exp_tog) begin
        n_fail++;
        $display("FAIL toggle_pulse n=%0d: got %h, required %h", n, toggle_pulse, exp_tog);
      end
      n_checks++;
      if (led_state !== exp_led) begin
        n_fail++;
        $display("FAIL toggle_led n=%0d: got %h, required %h", n, led_state, exp_led);
      end
      @(posedge clk); #1;
    end
    $display("test_toggle: done");
  endtask

  // Pressed 2, released 1, pressed 3: the bounce is rejected, the third
  // consecutive pressed frame toggles the lamp back off.
  task automatic test_bounce();
    logic [5:0]  pat = 6'b111011;
    int          tn  = 5 * 64 + 5;
    logic [11:0] exp_tog;
    logic [11:0] exp_led;
    key_held = 1'b0;
    wait_slot_start(1);
    for (int n = 0; n < 6 * 64; n++) begin
      if (n % 64 == 0) key_held = pat[n / 64];
      exp_tog = (n == tn) ? 12'h020 : 12'h000;
      exp_led = (n >= tn) ? 12'hFFF : 12'hFDF;
      n_checks++;
      if (toggle_pulse !== exp_tog) begin
        n_fail++;
        $display("FAIL bounce_pulse n=%0d: got %h, required %h", n, toggle_pulse, exp_tog);
      end
      n_checks++;
      if (led_state !== exp_led) begin
        n_fail++;
        $display("FAIL bounce_led n=%0d: got %h, required %h", n, led_state, exp_led);
      end
      @(posedge clk); #1;
    end
    $display("test_bounce: done");
  endtask

  task automatic test_enable_stop();
    key_held = 1'b0;
    wait_slot_start(2);
    repeat (5) begin @(posedge clk); #1; end
    enable = 1'b0;
    for (int n = 5; n < 16; n++) begin
      n_checks++;
      if (row_drive !== 4'b1011 || scan_row !== 2'd2) begin
        n_fail++;
        $display("FAIL stop_hold n=%0d: got rows=%b row=%0d, required 1011/2", n, row_drive, scan_row);
      end
      @(posedge clk); #1;
    end
    for (int n = 16; n < 26; n++) begin
      n_checks++;
      if (row_drive !== 4'b1111 || scan_row !== 2'd2 || frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL stop_idle n=%0d: got rows=%b row=%0d fd=%b, required 1111/2/0", n, row_drive, scan_row, frame_done);
      end
      @(posedge clk); #1;
    end
    enable = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n < 16; n++) begin
      n_checks++;
      if (row_drive !== 4'b1110 || scan_row !== 2'd0 || frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL restart_row0 n=%0d: got rows=%b row=%0d fd=%b, required 1110/0/0", n, row_drive, scan_row, frame_done);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (row_drive !== 4'b1101 || scan_row !== 2'd1) begin
      n_fail++;
      $display("FAIL restart_row1: got rows=%b row=%0d, required 1101/1", row_drive, scan_row);
    end
    $display("test_enable_stop: done");
  endtask

  task automatic test_reset_mid_slot();
    logic [5:0]  pat = 6'b111000;
    int          tn  = 5 * 64 + 5;
    logic [11:0] exp_tog;
    logic [11:0] exp_led;
    // Bring lamp 5 on: the debounced key is still pressed from the previous
    // scenario, so release it first and then press it again.
    wait_slot_start(1);
    for (int n = 0; n < 6 * 64; n++) begin
      if (n % 64 == 0) key_held = pat[n / 64];
      exp_tog = (n == tn) ? 12'h020 : 12'h000;
      exp_led = (n >= tn) ? 12'hFDF : 12'hFFF;
      n_checks++;
      if (toggle_pulse !== exp_tog || led_state !== exp_led) begin
        n_fail++;
        $display("FAIL relamp n=%0d: got tog=%h led=%h, required %h/%h", n, toggle_pulse, led_state, exp_tog, exp_led);
      end
      @(posedge clk); #1;
    end
    repeat (8) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (row_drive !== 4'b1111 || scan_row !== 2'd0 || led_state !== 12'hFFF ||
        toggle_pulse !== 12'h000 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_slot: got rows=%b row=%0d led=%h tog=%h fd=%b, required 1111/0/fff/000/0",
               row_drive, scan_row, led_state, toggle_pulse, frame_done);
    end
    rst = 1'b0;
    // Key still held: a cleared debouncer sees a fresh press and toggles on
    // the third row-1 sample after reset.
    wait_slot_start(1);
    tn = 2 * 64 + 5;
    for (int n = 0; n < 3 * 64; n++) begin
      exp_tog = (n == tn) ? 12'h020 : 12'h000;
      exp_led = (n >= tn) ? 12'hFDF : 12'hFFF;
      n_checks++;
      if (toggle_pulse !== exp_tog || led_state !== exp_led) begin
        n_fail++;
        $display("FAIL post_reset_debounce n=%0d: got tog=%h led=%h, required %h/%h", n, toggle_pulse, led_state, exp_tog, exp_led);
      end
      @(posedge clk); #1;
    end
    $display("test_reset_mid_slot: done");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    enable   = 1'b0;
    key_held = 1'b0;
    test_reset();
    test_scan();
    test_toggle();
    test_bounce();
    test_enable_stop();
    test_reset_mid_slot();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
